// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator for the decode stage.
//
// Decodes a 32-bit instruction into a sign-extended immediate, a format code
// and an illegal-opcode flag. The decode result is written into a 2-entry
// circular FIFO (skid buffer). This lets fetch keep streaming while the rest
// of decode is stalled.
//
// Parameters
//   XLEN   immediate width (32 or 64)
//   CNT_W  illegal counter width (only used with IMM_GEN_ILLEGAL_CNT_EN)
//
// Ports
//   clk, arst_n            clock, async active-low reset
//   in_valid/in_ready      input handshake; in_ready = (count != 2), registered only
//   in_instr               raw instruction
//   out_valid/out_ready    output handshake; out_valid = (count != 0)
//   out_imm                sign-extended immediate of the head entry
//   out_fmt                0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   out_illegal            head opcode unsupported
//   illegal_cnt            saturating count of accepted illegal instructions
//
// Optional feature: define IMM_GEN_ILLEGAL_CNT_EN to add the illegal_cnt port
// and its counter.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef IMM_GEN_ILLEGAL_CNT_EN
  ,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                         FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5,
                         FMT_X = 3'd7;

  // ---------------- combinational decode ----------------
  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;
  logic            s;

  assign s = in_instr[31];

  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_X;
    dec_ill = 1'b0;
    unique case (in_instr[6:0])
      7'b0110011, 7'b0111011: dec_fmt = FMT_R;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        imm32   = {{20{s}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{s}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{19{s}}, s, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{11{s}}, s, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: begin
        dec_fmt = FMT_X;
        dec_ill = 1'b1;
      end
    endcase
  end

  // imm32 already carries instr[31] in its MSB for every format, so a signed
  // cast extends correctly for both XLEN values (U-type included).
  assign dec_imm = XLEN'($signed(imm32));

  // ---------------- 2-entry circular FIFO ----------------
  logic [XLEN-1:0] imm_q [2];
  logic [2:0]      fmt_q [2];
  logic            ill_q [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            push, pop;

  // Ready depends only on registered count: no path from out_ready, so a pop
  // at count=2 frees the slot only from the following cycle.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= '0;
        ill_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        imm_q[wr_ptr_q] <= dec_imm;
        fmt_q[wr_ptr_q] <= dec_fmt;
        ill_q[wr_ptr_q] <= dec_ill;
      end
    end
  end

  assign out_imm     = imm_q[rd_ptr_q];
  assign out_fmt     = fmt_q[rd_ptr_q];
  assign out_illegal = ill_q[rd_ptr_q];

  // ---------------- optional illegal counter ----------------
`ifdef IMM_GEN_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  // Counted at accept time, saturating at all-ones.
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (push && dec_ill && (illegal_cnt_q != '1))
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) illegal_cnt_q <= '0;
    else         illegal_cnt_q <= illegal_cnt_d;
  end

  assign illegal_cnt = illegal_cnt_q;
`else
  // CNT_W has no role without the counter; this empty block only keeps the
  // parameter referenced.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
